// File: rtl/dcache_refill_ctrl_pkg.sv
// Purpose: shared geometry and refill FSM state encoding for the dcache refill slice.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: default cache geometry (N_WAYS, LINE_OFF_W, ADDR_W, LINE_W, BUS_W),
//           derived widths (OFFSET_W, TAG_W, BEATS) and refill_state_t.
package dcache_config;

  localparam int N_WAYS     = 2;
  localparam int LINE_OFF_W = 8;
  localparam int ADDR_W     = 32;
  localparam int LINE_W     = 128;
  localparam int BUS_W      = 32;

  // Byte offset inside a line, tag is whatever is left of the address.
  localparam int OFFSET_W   = $clog2(LINE_W / 8);
  localparam int TAG_W      = ADDR_W - LINE_OFF_W - OFFSET_W;
  localparam int BEATS      = LINE_W / BUS_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    FILL    = 3'd5
  } refill_state_t;

endpackage

// File: rtl/dcache_refill_buf.sv
// Purpose: beat counter and line assembly buffer for cache refills.
// Latency: a beat lands in the line one cycle after beat_valid; last is decoded from the counter.
// Backpressure: none; every beat_valid is consumed, the caller gates it by FSM state.
// Ports: clk, reset (sync, active-low), clear (restart at beat 0), beat_valid/beat_data
//        (incoming bus beat), line (assembled line), last (next beat completes the line).
module dcache_refill_buf #(
  parameter int LINE_W = 128,
  parameter int BUS_W  = 32,
  localparam int BEATS = LINE_W / BUS_W,
  localparam int CNT_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [BUS_W-1:0]  beat_data,
  output logic [LINE_W-1:0] line,
  output logic              last
);

  logic [CNT_W-1:0] cnt;

  // BEATS is a power of two, so the counter wraps by itself after the last beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (beat_valid) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Line contents are don't-care until all beats have landed, so no reset here.
  always_ff @(posedge clk) begin
    if (beat_valid && !clear) begin
      line[cnt*BUS_W +: BUS_W] <= beat_data;
    end
  end

  assign last = (cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Purpose: dcache miss handler: optional dirty-victim writeback, beat-wise refill, array fill, PLRU touch.
// Latency: clean miss accepted at T -> rd_req_valid at T+1, fill_en at T+2+BEATS with back-to-back beats.
// Backpressure: one miss in flight; miss_ready only in IDLE, wr/rd requests held until their ready.
// Ports: miss_* (request in), victim_* (PLRU victim info), wr_req_*/wr_done (writeback bus),
//        rd_req_*/rd_data* (refill bus), fill_* (array write), plru_* (PLRU update),
//        refill_done/busy (status), perf_* (counters).
// Build option: define DCACHE_REFILL_PERF_CNT_EN to enable perf_refill_cnt/perf_wb_cnt; otherwise both read 0.
module dcache_refill_ctrl #(
  parameter int N_WAYS     = dcache_config::N_WAYS,
  parameter int LINE_OFF_W = dcache_config::LINE_OFF_W,
  parameter int ADDR_W     = dcache_config::ADDR_W,
  parameter int LINE_W     = dcache_config::LINE_W,
  parameter int BUS_W      = dcache_config::BUS_W,
  localparam int OFFSET_W  = $clog2(LINE_W / 8),
  localparam int TAG_W     = ADDR_W - LINE_OFF_W - OFFSET_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_W-1:0]     miss_addr,
  input  logic [N_WAYS-1:0]     victim_way,
  input  logic                  victim_valid,
  input  logic                  victim_dirty,
  input  logic [TAG_W-1:0]      victim_tag,
  input  logic [LINE_W-1:0]     victim_data,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [ADDR_W-1:0]     wr_req_addr,
  output logic [LINE_W-1:0]     wr_req_data,
  input  logic                  wr_done,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_W-1:0]     rd_req_addr,
  input  logic                  rd_data_valid,
  input  logic [BUS_W-1:0]      rd_data,
  output logic                  fill_en,
  output logic [N_WAYS-1:0]     fill_way,
  output logic [LINE_OFF_W-1:0] fill_index,
  output logic [TAG_W-1:0]      fill_tag,
  output logic [LINE_W-1:0]     fill_data,
  output logic                  plru_we,
  output logic [N_WAYS-1:0]     plru_way_hit,
  output logic [LINE_OFF_W-1:0] plru_line_addr,
  output logic                  refill_done,
  output logic                  busy,
  output logic [31:0]           perf_refill_cnt,
  output logic [31:0]           perf_wb_cnt
);

  import dcache_config::*;

  refill_state_t state;

  // Miss context captured at accept; everything downstream is driven from these.
  logic [TAG_W-1:0]      miss_tag_q;
  logic [LINE_OFF_W-1:0] index_q;
  logic [N_WAYS-1:0]     way_q;
  logic [TAG_W-1:0]      victim_tag_q;
  logic [LINE_W-1:0]     victim_data_q;

  logic buf_clear;
  logic buf_beat;
  logic buf_last;

  // Byte-offset bits of the miss address are irrelevant: all requests are line aligned.
  logic unused_offset_bits;
  assign unused_offset_bits = ^miss_addr[OFFSET_W-1:0];

  // The buffer only sees beats while the FSM is collecting them; stray beats elsewhere vanish.
  assign buf_clear = (state == RD_REQ) && rd_req_ready;
  assign buf_beat  = (state == RD_DATA) && rd_data_valid;

  dcache_refill_buf #(
    .LINE_W (LINE_W),
    .BUS_W  (BUS_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .clear      (buf_clear),
    .beat_valid (buf_beat),
    .beat_data  (rd_data),
    .line       (fill_data),
    .last       (buf_last)
  );

  // Single FSM block; 1-bit outputs are registered alongside the next state so they
  // always match the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      miss_ready   <= 1'b1;
      busy         <= 1'b0;
      wr_req_valid <= 1'b0;
      rd_req_valid <= 1'b0;
      fill_en      <= 1'b0;
      plru_we      <= 1'b0;
      refill_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_valid && miss_ready) begin
            miss_tag_q    <= miss_addr[ADDR_W-1 -: TAG_W];
            index_q       <= miss_addr[OFFSET_W +: LINE_OFF_W];
            way_q         <= victim_way;
            victim_tag_q  <= victim_tag;
            victim_data_q <= victim_data;
            miss_ready    <= 1'b0;
            busy          <= 1'b1;
            if (victim_valid && victim_dirty) begin
              state        <= WB_REQ;
              wr_req_valid <= 1'b1;
            end else begin
              state        <= RD_REQ;
              rd_req_valid <= 1'b1;
            end
          end
        end
        WB_REQ: begin
          if (wr_req_ready) begin
            state        <= WB_WAIT;
            wr_req_valid <= 1'b0;
          end
        end
        WB_WAIT: begin
          if (wr_done) begin
            state        <= RD_REQ;
            rd_req_valid <= 1'b1;
          end
        end
        RD_REQ: begin
          if (rd_req_ready) begin
            state        <= RD_DATA;
            rd_req_valid <= 1'b0;
          end
        end
        RD_DATA: begin
          if (rd_data_valid && buf_last) begin
            state       <= FILL;
            fill_en     <= 1'b1;
            plru_we     <= 1'b1;
            refill_done <= 1'b1;
          end
        end
        FILL: begin
          state       <= IDLE;
          fill_en     <= 1'b0;
          plru_we     <= 1'b0;
          refill_done <= 1'b0;
          miss_ready  <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          miss_ready   <= 1'b1;
          busy         <= 1'b0;
          wr_req_valid <= 1'b0;
          rd_req_valid <= 1'b0;
          fill_en      <= 1'b0;
          plru_we      <= 1'b0;
          refill_done  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_req_addr    = {victim_tag_q, index_q, {OFFSET_W{1'b0}}};
  assign wr_req_data    = victim_data_q;
  assign rd_req_addr    = {miss_tag_q, index_q, {OFFSET_W{1'b0}}};
  assign fill_way       = way_q;
  assign fill_index     = index_q;
  assign fill_tag       = miss_tag_q;
  assign plru_way_hit   = way_q;
  assign plru_line_addr = index_q;

`ifdef DCACHE_REFILL_PERF_CNT_EN
  logic [31:0] refill_cnt_q;
  logic [31:0] wb_cnt_q;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      refill_cnt_q <= '0;
      wb_cnt_q     <= '0;
    end else begin
      if ((state == WB_REQ) && wr_req_ready) begin
        wb_cnt_q <= wb_cnt_q + 32'd1;
      end
      if (state == FILL) begin
        refill_cnt_q <= refill_cnt_q + 32'd1;
      end
    end
  end

  assign perf_refill_cnt = refill_cnt_q;
  assign perf_wb_cnt     = wb_cnt_q;
`else
  assign perf_refill_cnt = 32'd0;
  assign perf_wb_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Purpose: directed self-checking bench for dcache_refill_ctrl (default geometry: 2 ways, 128b line, 32b beats).
// Latency: checks are taken 1ns after each rising edge, inputs change at the same point.
// Backpressure: exercises held wr/rd requests, gapped beats and a miss held through FILL.
module tb_dcache_refill_ctrl;

  logic          clk = 1'b0;
  logic          reset;
  logic          miss_valid;
  logic          miss_ready;
  logic [31:0]   miss_addr;
  logic [1:0]    victim_way;
  logic          victim_valid;
  logic          victim_dirty;
  logic [19:0]   victim_tag;
  logic [127:0]  victim_data;
  logic          wr_req_valid;
  logic          wr_req_ready;
  logic [31:0]   wr_req_addr;
  logic [127:0]  wr_req_data;
  logic          wr_done;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [31:0]   rd_req_addr;
  logic          rd_data_valid;
  logic [31:0]   rd_data;
  logic          fill_en;
  logic [1:0]    fill_way;
  logic [7:0]    fill_index;
  logic [19:0]   fill_tag;
  logic [127:0]  fill_data;
  logic          plru_we;
  logic [1:0]    plru_way_hit;
  logic [7:0]    plru_line_addr;
  logic          refill_done;
  logic          busy;
  logic [31:0]   perf_refill_cnt;
  logic [31:0]   perf_wb_cnt;

  int checks = 0;
  int errors = 0;

`ifdef DCACHE_REFILL_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  dcache_refill_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .miss_valid     (miss_valid),
    .miss_ready     (miss_ready),
    .miss_addr      (miss_addr),
    .victim_way     (victim_way),
    .victim_valid   (victim_valid),
    .victim_dirty   (victim_dirty),
    .victim_tag     (victim_tag),
    .victim_data    (victim_data),
    .wr_req_valid   (wr_req_valid),
    .wr_req_ready   (wr_req_ready),
    .wr_req_addr    (wr_req_addr),
    .wr_req_data    (wr_req_data),
    .wr_done        (wr_done),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_req_addr    (rd_req_addr),
    .rd_data_valid  (rd_data_valid),
    .rd_data        (rd_data),
    .fill_en        (fill_en),
    .fill_way       (fill_way),
    .fill_index     (fill_index),
    .fill_tag       (fill_tag),
    .fill_data      (fill_data),
    .plru_we        (plru_we),
    .plru_way_hit   (plru_way_hit),
    .plru_line_addr (plru_line_addr),
    .refill_done    (refill_done),
    .busy           (busy),
    .perf_refill_cnt(perf_refill_cnt),
    .perf_wb_cnt    (perf_wb_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int n);
    return PERF_ON ? 32'(n) : 32'd0;
  endfunction

  // Drives four beats starting in RD_DATA, with 'gap' idle cycles between beats.
  // Returns with the DUT expected to be in FILL.
  task automatic feed_beats(input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3, input int gap);
    logic [31:0] beats [4];
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    for (int i = 0; i < 4; i++) begin
      rd_data_valid = 1'b1;
      rd_data       = beats[i];
      step();
      rd_data_valid = 1'b0;
      rd_data       = 32'hDEAD_0000;
      if (i < 3) begin
        chk("no_fill_mid_beats", fill_en, 1'b0);
        for (int g = 0; g < gap; g++) begin
          step();
          chk("no_fill_in_gap", fill_en, 1'b0);
        end
      end
    end
  endtask

  task automatic chk_fill(input logic [127:0] line, input logic [1:0] way, input logic [7:0] idx);
    chk("fill_en", fill_en, 1'b1);
    chk("plru_we", plru_we, 1'b1);
    chk("refill_done", refill_done, 1'b1);
    chk("fill_data", fill_data, line);
    chk("fill_way", fill_way, way);
    chk("plru_way_hit", plru_way_hit, way);
    chk("fill_index", fill_index, idx);
    chk("plru_line_addr", plru_line_addr, idx);
  endtask

  initial begin
    reset         = 1'b0;
    miss_valid    = 1'b0;
    miss_addr     = '0;
    victim_way    = '0;
    victim_valid  = 1'b0;
    victim_dirty  = 1'b0;
    victim_tag    = '0;
    victim_data   = '0;
    wr_req_ready  = 1'b0;
    wr_done       = 1'b0;
    rd_req_ready  = 1'b0;
    rd_data_valid = 1'b0;
    rd_data       = '0;

    // ---- reset state
    step();
    step();
    chk("rst_miss_ready", miss_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_req_valid", wr_req_valid, 1'b0);
    chk("rst_rd_req_valid", rd_req_valid, 1'b0);
    chk("rst_fill_en", fill_en, 1'b0);
    chk("rst_refill_done", refill_done, 1'b0);
    chk("rst_perf_refill", perf_refill_cnt, 32'd0);
    chk("rst_perf_wb", perf_wb_cnt, 32'd0);
    reset = 1'b1;
    step();

    // ---- clean miss, back-to-back beats
    miss_valid   = 1'b1;
    miss_addr    = 32'h0000_1230;
    victim_way   = 2'b10;
    victim_valid = 1'b1;
    victim_dirty = 1'b0;
    victim_tag   = 20'h00007;
    victim_data  = 128'h1;
    step();                                   // accepted, now T+1
    miss_valid = 1'b0;
    chk("clean_rd_req_valid", rd_req_valid, 1'b1);
    chk("clean_wr_req_valid", wr_req_valid, 1'b0);
    chk("clean_miss_ready", miss_ready, 1'b0);
    chk("clean_busy", busy, 1'b1);
    chk("clean_rd_req_addr", rd_req_addr, 32'h0000_1230);
    chk("clean_fill_tag", fill_tag, 20'h00001);
    rd_req_ready = 1'b1;
    step();                                   // T+2, RD_DATA
    rd_req_ready = 1'b0;
    chk("clean_rd_req_drop", rd_req_valid, 1'b0);
    feed_beats(32'h11, 32'h22, 32'h33, 32'h44, 0);   // now T+2+BEATS
    chk_fill(128'h00000044_00000033_00000022_00000011, 2'b10, 8'h23);
    chk("clean_fill_miss_ready", miss_ready, 1'b0);
    step();                                   // T+3+BEATS
    chk("clean_done_miss_ready", miss_ready, 1'b1);
    chk("clean_done_fill_en", fill_en, 1'b0);
    chk("clean_done_busy", busy, 1'b0);
    chk("clean_perf_refill", perf_refill_cnt, perf_exp(1));

    // ---- dirty victim, held wr/rd ready, spurious beat in WB_WAIT, gapped beats
    miss_valid   = 1'b1;
    miss_addr    = 32'h0000_1230;
    victim_way   = 2'b01;
    victim_valid = 1'b1;
    victim_dirty = 1'b1;
    victim_tag   = 20'h00005;
    victim_data  = 128'hCAFEBABE_01234567_89ABCDEF_DEADBEEF;
    step();
    miss_valid  = 1'b0;
    victim_data = '0;
    victim_tag  = '0;
    chk("dirty_wr_req_valid", wr_req_valid, 1'b1);
    chk("dirty_rd_req_valid", rd_req_valid, 1'b0);
    chk("dirty_wr_req_addr", wr_req_addr, 32'h0000_5230);
    chk("dirty_wr_req_data", wr_req_data, 128'hCAFEBABE_01234567_89ABCDEF_DEADBEEF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wr_hold_valid", wr_req_valid, 1'b1);
      chk("wr_hold_addr", wr_req_addr, 32'h0000_5230);
    end
    wr_req_ready = 1'b1;
    step();                                   // WB_WAIT
    wr_req_ready = 1'b0;
    chk("wb_wait_wr_req_valid", wr_req_valid, 1'b0);
    chk("wb_wait_rd_req_valid", rd_req_valid, 1'b0);
    chk("dirty_perf_wb", perf_wb_cnt, perf_exp(1));
    rd_data_valid = 1'b1;                     // stray beat, must be ignored
    rd_data       = 32'hBAD0_BAD0;
    step();
    rd_data_valid = 1'b0;
    step();
    chk("wb_wait_still_no_rd", rd_req_valid, 1'b0);
    wr_done = 1'b1;
    step();                                   // RD_REQ
    wr_done = 1'b0;
    chk("after_wr_done_rd_req_valid", rd_req_valid, 1'b1);
    chk("dirty_rd_req_addr", rd_req_addr, 32'h0000_1230);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rd_hold_valid", rd_req_valid, 1'b1);
      chk("rd_hold_addr", rd_req_addr, 32'h0000_1230);
    end
    rd_req_ready = 1'b1;
    step();
    rd_req_ready = 1'b0;
    feed_beats(32'hA0, 32'hA1, 32'hA2, 32'hA3, 3);
    chk_fill(128'h000000A3_000000A2_000000A1_000000A0, 2'b01, 8'h23);
    step();
    chk("dirty_done_fill_en", fill_en, 1'b0);
    chk("dirty_done_miss_ready", miss_ready, 1'b1);
    chk("dirty_perf_refill", perf_refill_cnt, perf_exp(2));
    chk("dirty_perf_wb_final", perf_wb_cnt, perf_exp(1));

    // ---- reset in the middle of RD_DATA
    miss_valid   = 1'b1;
    miss_addr    = 32'h0000_2340;
    victim_way   = 2'b01;
    victim_valid = 1'b0;
    victim_dirty = 1'b1;
    step();
    miss_valid   = 1'b0;
    rd_req_ready = 1'b1;
    step();
    rd_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_data_valid = 1'b1;
      rd_data       = 32'h55 + 32'(i);
      step();
    end
    rd_data_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort_miss_ready", miss_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_fill_en", fill_en, 1'b0);
    chk("abort_rd_req_valid", rd_req_valid, 1'b0);
    chk("abort_perf_refill", perf_refill_cnt, 32'd0);
    step();
    chk("abort_no_fill", fill_en, 1'b0);
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_2340;
    step();
    miss_valid = 1'b0;
    chk("post_abort_rd_req_addr", rd_req_addr, 32'h0000_2340);
    rd_req_ready = 1'b1;
    step();
    rd_req_ready = 1'b0;
    feed_beats(32'h1, 32'h2, 32'h3, 32'h4, 0);
    chk_fill(128'h00000004_00000003_00000002_00000001, 2'b01, 8'h34);
    step();

    // ---- miss held through FILL; counters start from a fresh reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    miss_valid   = 1'b1;
    miss_addr    = 32'h0000_1230;
    victim_way   = 2'b10;
    victim_valid = 1'b1;
    victim_dirty = 1'b0;
    step();
    rd_req_ready = 1'b1;
    step();
    rd_req_ready = 1'b0;
    feed_beats(32'h7, 32'h8, 32'h9, 32'hA, 0);
    chk("held_fill_en", fill_en, 1'b1);
    chk("held_fill_miss_ready", miss_ready, 1'b0);
    miss_addr  = 32'h0000_3450;
    victim_way = 2'b01;
    step();                                   // IDLE, second miss accepted at next edge
    chk("held_idle_miss_ready", miss_ready, 1'b1);
    chk("held_idle_busy", busy, 1'b0);
    chk("held_idle_fill_en", fill_en, 1'b0);
    step();
    miss_valid = 1'b0;
    chk("held_second_rd_req_valid", rd_req_valid, 1'b1);
    chk("held_second_rd_req_addr", rd_req_addr, 32'h0000_3450);
    chk("held_second_fill_way", fill_way, 2'b01);
    rd_req_ready = 1'b1;
    step();
    rd_req_ready = 1'b0;
    feed_beats(32'hB1, 32'hB2, 32'hB3, 32'hB4, 0);
    chk_fill(128'h000000B4_000000B3_000000B2_000000B1, 2'b01, 8'h45);
    step();
    chk("held_perf_refill", perf_refill_cnt, perf_exp(2));
    chk("held_perf_wb", perf_wb_cnt, 32'd0);
    chk("held_end_miss_ready", miss_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
